// File: rtl/ultrasound_sweep_collector_if.sv
// Bundle between the sweep collector, the ranger/servo side and the downstream
// min-index stage.
interface ultrasound_sweep_collector_if;
  // Handshake: meas_valid is a one-cycle strobe with no ready; it is consumed
  // only while the collector waits for an echo. start is a level request
  // sampled in IDLE. sweep_done is a one-cycle strobe that marks dist1..dist5
  // and timeout_mask as a freshly loaded coherent set.
  logic       start;
  logic       meas_valid;
  logic [7:0] meas_distance;
  logic       ultrasound_trigger;
  logic [2:0] angle_sel;
  logic       busy;
  logic [7:0] dist1;
  logic [7:0] dist2;
  logic [7:0] dist3;
  logic [7:0] dist4;
  logic [7:0] dist5;
  logic [4:0] timeout_mask;
  logic       sweep_done;
  logic [2:0] state_dbg;

  modport slave (
    input  start, meas_valid, meas_distance,
    output ultrasound_trigger, angle_sel, busy,
    output dist1, dist2, dist3, dist4, dist5, timeout_mask, sweep_done, state_dbg
  );

  modport master (
    output start, meas_valid, meas_distance,
    input  ultrasound_trigger, angle_sel, busy,
    input  dist1, dist2, dist3, dist4, dist5, timeout_mask, sweep_done, state_dbg
  );
endinterface

// File: rtl/ultrasound_sweep_collector.sv
// Sweeps five beam angles, captures one ranger distance per angle and
// publishes all five as one registered set with a done pulse.
module ultrasound_sweep_collector #(
    parameter int SETTLE_CYCLES  = 2700000,
    parameter int TIMEOUT_CYCLES = 2700000,
    parameter int CNT_W          = 22
) (
    input logic clock,
    input logic reset,
    ultrasound_sweep_collector_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_TRIGGER = 3'd2,
        S_WAIT    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       angle_q, angle_d;
    logic [7:0]       slot_q [5];
    logic [7:0]       slot_d [5];
    logic [4:0]       smask_q, smask_d;
    logic [7:0]       dist_q [5];
    logic [7:0]       dist_d [5];
    logic [4:0]       omask_q, omask_d;
    logic             store;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            angle_q <= 3'd1;
            slot_q  <= '{default: '0};
            smask_q <= '0;
            dist_q  <= '{default: '0};
            omask_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            angle_q <= angle_d;
            slot_q  <= slot_d;
            smask_q <= smask_d;
            dist_q  <= dist_d;
            omask_q <= omask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        angle_d = angle_q;
        slot_d  = slot_q;
        smask_d = smask_q;
        dist_d  = dist_q;
        omask_d = omask_q;
        store   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    angle_d = 3'd1;
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_TRIGGER;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_TRIGGER: state_d = S_WAIT;
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A measurement arriving on the expiry clock takes priority.
                for (int k = 0; k < 5; k++) begin
                    if (angle_q == 3'(k + 1)) begin
                        if (bus.meas_valid) begin
                            slot_d[k]  = bus.meas_distance;
                            smask_d[k] = 1'b0;
                            store      = 1'b1;
                        end else if (cnt_q == TIMEOUT_LAST) begin
                            slot_d[k]  = 8'hFF;
                            smask_d[k] = 1'b1;
                            store      = 1'b1;
                        end
                    end
                end
                if (store) begin
                    cnt_d = '0;
                    if (angle_q == 3'd5) begin
                        // Publish on the edge entering DONE so the set is never partial.
                        dist_d  = slot_d;
                        omask_d = smask_d;
                        state_d = S_DONE;
                    end else begin
                        angle_d = angle_q + 3'd1;
                        state_d = S_SETTLE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.ultrasound_trigger = (state_q == S_TRIGGER);
    assign bus.busy               = (state_q != S_IDLE);
    assign bus.sweep_done         = (state_q == S_DONE);
    assign bus.angle_sel          = angle_q;
    assign bus.dist1              = dist_q[0];
    assign bus.dist2              = dist_q[1];
    assign bus.dist3              = dist_q[2];
    assign bus.dist4              = dist_q[3];
    assign bus.dist5              = dist_q[4];
    assign bus.timeout_mask       = omask_q;
    assign bus.state_dbg          = state_q;

endmodule

// File: doc/ultrasound_sweep_collector.md
Name: ultrasound_sweep_collector

Overview:
- Sequences one ultrasonic ranging sweep across 5 fixed beam angles (slots 1..5).
- Per slot: selects the angle, waits for mechanical settle, fires the ranger, and captures one 8-bit distance.
- Presents all 5 distances as one coherent registered set, with a done pulse, to the combinational 5-way min-index stage directly downstream.

Parameters:
- SETTLE_CYCLES, 2700000: clocks held at each new angle before triggering (100 ms at 27 MHz).
- TIMEOUT_CYCLES, 2700000: clocks to wait for a measurement after the trigger before declaring no echo.
- CNT_W, 22: width of the shared settle/timeout counter; must hold max(SETTLE_CYCLES, TIMEOUT_CYCLES).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request a sweep; sampled only in IDLE.
- meas_valid  in  1  one-cycle strobe from the ranger; meas_distance is valid.
- meas_distance  in  8  echo distance, unsigned.
- ultrasound_trigger  out  1  one-cycle pulse that fires the ranger.
- angle_sel  out  3  current slot 1..5; drives servo/transducer select.
- busy  out  1  high in every state except IDLE.
- dist1..dist5  out  8 each  registered sweep result; slot k on distk.
- timeout_mask  out  5  bit k-1 set if slot k timed out.
- sweep_done  out  1  one-cycle pulse when dist1..5 and timeout_mask update.

Behaviour:
- One clock. Reset is asynchronous, active-high.
- Reset values:
  - State IDLE; angle_sel=1; counter=0.
  - ultrasound_trigger=0, busy=0, sweep_done=0.
  - dist1..5=0, timeout_mask=0, internal slot registers=0.
- States: IDLE, SETTLE, TRIGGER, WAIT, DONE.
- IDLE:
  - If start is sampled high: angle_sel<=1, counter<=0, go to SETTLE.
  - start is ignored in all other states; there is no queuing.
- SETTLE:
  - Counter increments each clock.
  - At counter==SETTLE_CYCLES-1: counter<=0, go to TRIGGER.
  - Duration is exactly SETTLE_CYCLES clocks.
- TRIGGER:
  - Exactly one clock with ultrasound_trigger=1; then go to WAIT.
- WAIT:
  - Counter increments each clock.
  - If meas_valid: store meas_distance in slot[angle_sel] and clear its mask bit.
  - Else if counter==TIMEOUT_CYCLES-1: store 8'hFF in the slot and set its mask bit.
  - If meas_valid coincides with timeout expiry, the measurement wins.
  - After a store: if angle_sel==5 go to DONE; else angle_sel<=angle_sel+1, counter<=0, go to SETTLE.
- DONE:
  - On the edge entering DONE, dist1..5 and timeout_mask load from the slot registers.
  - In DONE: sweep_done=1 for one clock; then go to IDLE.
  - Downstream therefore never sees a partially updated set. Outputs hold until the next sweep's DONE.
- meas_valid outside WAIT is ignored and causes no store.
- A second meas_valid in the same slot cannot occur, because the state leaves WAIT on the first one.
- angle_sel is stable from entry to SETTLE through the store cycle; it never takes values 0, 6 or 7.
- Reset asserted mid-sweep aborts immediately to reset values, including the outputs. No sweep_done is produced.
- Distances pass through unmodified; no arithmetic on data.
- Latency, all responses immediate: start edge to first trigger = SETTLE_CYCLES+1 clocks. Sweep length = 5×(SETTLE_CYCLES+1+wait clocks)+1.

Test Plan (SETTLE_CYCLES=4, TIMEOUT_CYCLES=20, CNT_W=5):
- Reset then idle 10 clocks → all outputs 0, angle_sel=1, no trigger.
- Start pulse; ranger answers 3 clocks after each trigger with 40,30,20,35,50 → 5 triggers spaced 4+1+3 clocks apart; angle_sel steps 1..5; one sweep_done with dist1..5=40,30,20,35,50 and timeout_mask=0; busy falls the clock after done.
- Same sweep but slot 2 never answers → slot 2 trigger followed by exactly 20 WAIT clocks; dist2=8'hFF; timeout_mask=5'b00010; the other slots are correct.
- Slot 4 meas_valid=1 with distance 12 on the same clock the timeout expires → dist4=12, mask bit 3 clear. Stray meas_valid during SETTLE → no store.
- start pulses while busy, plus start held high through the sweep → only one sweep per IDLE entry. Holding start through DONE begins a new sweep from IDLE on the next clock.
- reset asserted during slot 3 WAIT → outputs clear asynchronously, state IDLE. A new sweep then completes normally with no residue from the aborted one.
